// File: rtl/mux_rr_sched.sv
// mux_rr_sched: round-robin arbiter that drives the select of an external
// 4:1 mux and captures the mux result into a valid/ready output register.
// Ports: clk, rst_n (async, active-low); req_valid/req_ready (4 requesters);
// sel -> external mux, mux_out <- external mux; out_data/out_valid/
// out_ready downstream handshake; grant_id = owner of out_data.
module mux_rr_sched #(
   parameter int unsigned DATA_W     = 4,
   parameter int unsigned PRIO_RESET = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [3:0]        req_valid,
   output logic [3:0]        req_ready,
   output logic [1:0]        sel,
   input  logic [DATA_W-1:0] mux_out,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [1:0]        grant_id
);

   localparam logic [1:0] PTR_RST = 2'(PRIO_RESET);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SEL  = 2'd1,
      HOLD = 2'd2
   } state_e;

   state_e            state_q, state_d;
   logic [1:0]        sel_q, sel_d;
   logic [1:0]        ptr_q, ptr_d;
   logic [1:0]        gnt_q, gnt_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              ov_q, ov_d;
   logic [1:0]        winner;

   // Walk the search order backwards so the first hit from ptr wins.
   always_comb begin
      winner = ptr_q;
      for (int k = 3; k >= 0; k--) begin
         if (req_valid[ptr_q + 2'(k)]) begin
            winner = ptr_q + 2'(k);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sel_q   <= 2'd0;
         ptr_q   <= PTR_RST;
         gnt_q   <= 2'd0;
         data_q  <= '0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         data_q  <= data_d;
         ov_q    <= ov_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      data_d  = data_q;
      ov_d    = ov_q;
      unique case (state_q)
         IDLE: begin
            if (|req_valid) begin
               sel_d   = winner;
               state_d = SEL;
            end
         end
         SEL: begin
            // A withdrawn request falls back to IDLE with ptr untouched.
            if (req_valid[sel_q]) begin
               data_d  = mux_out;
               gnt_d   = sel_q;
               ov_d    = 1'b1;
               state_d = HOLD;
            end else begin
               state_d = IDLE;
            end
         end
         HOLD: begin
            if (out_ready) begin
               ov_d    = 1'b0;
               ptr_d   = gnt_q + 2'd1;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_comb begin
      req_ready = 4'b0000;
      if (state_q == SEL && req_valid[sel_q]) begin
         req_ready = 4'b0001 << sel_q;
      end
   end

   assign sel       = sel_q;
   assign out_data  = data_q;
   assign out_valid = ov_q;
   assign grant_id  = gnt_q;

endmodule

// File: tb/tb_mux_rr_sched.sv
// tb_mux_rr_sched: directed and randomized bench for mux_rr_sched with an
// external 4:1 mux, a transaction-level reference model and a scoreboard.
module tb_mux_rr_sched;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req_valid = 4'b0000;
   logic [3:0] req_ready;
   logic [1:0] sel;
   logic [3:0] mux_out;
   logic [3:0] out_data;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [1:0] grant_id;
   logic [3:0] din [4] = '{4'h0, 4'h0, 4'h0, 4'h0};

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   assign mux_out = din[sel];

   mux_rr_sched #(.DATA_W(4), .PRIO_RESET(0)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .sel       (sel),
      .mux_out   (mux_out),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .grant_id  (grant_id)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference: transfer phase (0 free, 1 selected, 2 delivered),
   // owner of the current transfer, priority pointer, last select.
   int         m_stage = 0;
   int         m_own   = 0;
   int         m_ptr   = 0;
   int         m_sel   = 0;
   logic [5:0] sbq [$];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_stage = 0;
         m_own   = 0;
         m_ptr   = 0;
         m_sel   = 0;
         sbq.delete();
      end else begin
         case (m_stage)
            0: begin
               if (req_valid != 4'b0000) begin
                  for (int k = 0; k < 4; k++) begin
                     if (req_valid[(m_ptr + k) % 4]) begin
                        m_own = (m_ptr + k) % 4;
                        break;
                     end
                  end
                  m_sel   = m_own;
                  m_stage = 1;
               end
            end
            1: begin
               if (req_valid[m_own]) begin
                  sbq.push_back({2'(m_own), din[m_own]});
                  m_stage = 2;
               end else begin
                  m_stage = 0;
               end
            end
            default: begin
               if (out_ready) begin
                  m_ptr   = (m_own + 1) % 4;
                  m_stage = 0;
               end
            end
         endcase
      end
   end

   logic prev_ov = 1'b0;

   always @(posedge clk) begin
      logic [5:0] e;
      #2;
      chk("sel", sel, m_sel);
      chk("out_valid", out_valid, (m_stage == 2));
      chk("req_ready", req_ready,
          (m_stage == 1 && req_valid[m_own]) ? (1 << m_own) : 0);
      if (out_valid && !prev_ov) begin
         if (sbq.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL sb_unexpected: got id=%0d data=%0h expected none",
                     grant_id, out_data);
         end else begin
            e = sbq.pop_front();
            chk("sb_grant_id", grant_id, e[5:4]);
            chk("sb_out_data", out_data, e[3:0]);
         end
      end
      prev_ov = out_valid;
   end

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      req_valid = 4'b0000;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic wait_out(input int id, input int d, input string nm);
      bit seen = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (out_valid) begin
            seen = 1;
            break;
         end
      end
      if (!seen) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_timeout: got no out_valid expected id=%0d", nm, id);
      end else begin
         chk({nm, "_id"}, grant_id, id);
         chk({nm, "_data"}, out_data, d);
      end
   endtask

   logic [3:0] exp_d [4] = '{4'h1, 4'hF, 4'h7, 4'h9};

   initial begin
      logic [3:0] acc;
      logic [3:0] pend_drop;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_sel", sel, 0);
      chk("rst_grant", grant_id, 0);
      chk("rst_req_ready", req_ready, 0);
      rst_n = 1'b1;

      // single requester
      din[1]    = 4'h3;
      req_valid = 4'b0010;
      out_ready = 1'b1;
      @(negedge clk);
      chk("single_sel", sel, 1);
      chk("single_rdy", req_ready, 4'b0010);
      chk("single_ov0", out_valid, 0);
      @(negedge clk);
      chk("single_ov", out_valid, 1);
      chk("single_data", out_data, 4'h3);
      chk("single_id", grant_id, 1);
      chk("single_rdy0", req_ready, 0);
      req_valid = 4'b0000;
      @(negedge clk);
      chk("single_done", out_valid, 0);

      // all requesting: one grant every 3 cycles in rotation
      do_reset();
      for (int i = 0; i < 4; i++) din[i] = exp_d[i];
      req_valid = 4'b1111;
      out_ready = 1'b1;
      for (int n = 1; n <= 14; n++) begin
         @(negedge clk);
         if (n % 3 == 2) begin
            chk("all_ov", out_valid, 1);
            chk("all_id", grant_id, (n / 3) % 4);
            chk("all_data", out_data, exp_d[(n / 3) % 4]);
         end else begin
            chk("all_ov0", out_valid, 0);
         end
      end
      req_valid = 4'b0000;

      // backpressure
      do_reset();
      din[0]    = 4'hA;
      din[2]    = 4'h5;
      req_valid = 4'b0001;
      out_ready = 1'b0;
      repeat (2) @(negedge clk);
      req_valid = 4'b0100;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_ov", out_valid, 1);
         chk("bp_data", out_data, 4'hA);
         chk("bp_sel", sel, 0);
         chk("bp_rdy", req_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_done", out_valid, 0);
      @(negedge clk);
      chk("bp_next_sel", sel, 2);
      chk("bp_next_rdy", req_ready, 4'b0100);
      req_valid = 4'b0000;

      // wrap-around
      do_reset();
      din[3]    = 4'h5;
      din[0]    = 4'h6;
      out_ready = 1'b1;
      req_valid = 4'b1000;
      wait_out(3, 5, "wrap_a");
      req_valid = 4'b1001;
      wait_out(0, 6, "wrap_b");
      wait_out(3, 5, "wrap_c");
      req_valid = 4'b0000;

      // withdrawal keeps ptr
      do_reset();
      din[1]    = 4'h4;
      din[2]    = 4'hC;
      out_ready = 1'b1;
      req_valid = 4'b0010;
      wait_out(1, 4, "wd_pre");
      req_valid = 4'b0000;
      @(negedge clk);
      req_valid = 4'b0100;
      @(negedge clk);
      chk("wd_sel", sel, 2);
      chk("wd_rdy", req_ready, 4'b0100);
      req_valid = 4'b0000;
      #1;
      chk("wd_rdy0", req_ready, 0);
      @(negedge clk);
      chk("wd_ov", out_valid, 0);
      req_valid = 4'b0110;
      wait_out(2, 4'hC, "wd_ptr");
      req_valid = 4'b0000;

      // reset during HOLD
      do_reset();
      din[1]    = 4'h7;
      req_valid = 4'b0010;
      out_ready = 1'b0;
      wait_out(1, 7, "rh_pre");
      req_valid = 4'b0000;
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("rh_ov", out_valid, 0);
      chk("rh_data", out_data, 0);
      chk("rh_sel", sel, 0);
      chk("rh_id", grant_id, 0);
      @(negedge clk);
      rst_n     = 1'b1;
      din[0]    = 4'h1;
      din[2]    = 4'h2;
      req_valid = 4'b0101;
      out_ready = 1'b1;
      wait_out(0, 1, "rh_first");
      wait_out(2, 2, "rh_second");
      req_valid = 4'b0000;

      // randomized traffic against the reference model
      do_reset();
      pend_drop = 4'b0000;
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         acc = req_ready & req_valid;
         for (int i = 0; i < 4; i++) begin
            if (pend_drop[i]) begin
               req_valid[i] = 1'b0;
            end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
               req_valid[i] = 1'b1;
               din[i]       = 4'($urandom);
            end
         end
         pend_drop = acc;
         out_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      req_valid = req_valid & ~pend_drop;
      @(negedge clk);
      req_valid = 4'b0000;
      out_ready = 1'b1;
      repeat (10) @(negedge clk);
      chk("sb_drained", sbq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
